// File: rtl/afe_rx_pkg.sv
// Shared types and default widths for the AFE RX burst capture controller.
package afe_rx_pkg;

   // Capture sequencer states; encoding is fixed so status readback stays stable.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSkip    = 2'd1,
      StCapture = 2'd2
   } state_e;

   localparam int unsigned DEF_IQ_PAIR_WIDTH = 24;
   localparam int unsigned DEF_LEN_WIDTH     = 16;
   localparam int unsigned DEF_SKIP_WIDTH    = 8;
   localparam int unsigned DEF_DROP_WIDTH    = 16;

endpackage

// File: rtl/afe_rx_burst_ctrl_if.sv
// IQ stream from the deserializer plus the RX FIFO write port.
interface afe_rx_burst_ctrl_if #(
   parameter int unsigned IQ_PAIR_WIDTH = afe_rx_pkg::DEF_IQ_PAIR_WIDTH
) ();

   logic                     s_valid;
   logic [IQ_PAIR_WIDTH-1:0] s_data;
   logic                     fifo_full;
   logic                     fifo_wr;
   logic [IQ_PAIR_WIDTH-1:0] fifo_data;

   // Capture controller side: consumes the stream, drives the FIFO write port.
   modport slave (
      input  s_valid,
      input  s_data,
      input  fifo_full,
      output fifo_wr,
      output fifo_data
   );

   // Environment side: deserializer source and FIFO sink.
   modport master (
      output s_valid,
      output s_data,
      output fifo_full,
      input  fifo_wr,
      input  fifo_data
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Clear has priority over increment; increment stops at the ceiling.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/afe_rx_burst_ctrl.sv
// RX burst capture sequencer: arm, optional settling skip, then write a
// fixed-length (or unbounded) run of IQ pairs into the RX FIFO.
module afe_rx_burst_ctrl
   import afe_rx_pkg::*;
#(
   parameter int unsigned IQ_PAIR_WIDTH = DEF_IQ_PAIR_WIDTH,
   parameter int unsigned LEN_WIDTH     = DEF_LEN_WIDTH,
   parameter int unsigned SKIP_WIDTH    = DEF_SKIP_WIDTH,
   parameter int unsigned DROP_WIDTH    = DEF_DROP_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_start,
   input  logic                  cfg_stop,
   input  logic                  cfg_continuous,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [SKIP_WIDTH-1:0] cfg_skip,
   afe_rx_burst_ctrl_if.slave    bus,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  overflow,
   output logic [DROP_WIDTH-1:0] drop_cnt,
   output logic [LEN_WIDTH-1:0]  sample_cnt
);

   state_e                   state_q, state_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic [LEN_WIDTH-1:0]     sample_q, sample_d, sample_inc;
   logic [SKIP_WIDTH-1:0]    skip_q, skip_d;
   logic                     cont_q, cont_d;
   logic                     fifo_wr_q, fifo_wr_d;
   logic [IQ_PAIR_WIDTH-1:0] fifo_data_q, fifo_data_d;
   logic                     done_q, done_d;
   logic                     aborted_q, aborted_d;
   logic                     overflow_q, overflow_d;
   logic                     drop_clr, drop_inc;

   assign sample_inc = sample_q + LEN_WIDTH'(1);

   // Next-state and registered-output decode; stop outranks everything.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      sample_d    = sample_q;
      skip_d      = skip_q;
      cont_d      = cont_q;
      fifo_wr_d   = 1'b0;
      fifo_data_d = fifo_data_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      overflow_d  = overflow_q;
      drop_clr    = 1'b0;
      drop_inc    = 1'b0;

      case (state_q)
         StIdle: begin
            if (cfg_start && !cfg_stop) begin
               len_d      = cfg_len;
               skip_d     = cfg_skip;
               cont_d     = cfg_continuous;
               sample_d   = '0;
               overflow_d = 1'b0;
               drop_clr   = 1'b1;
               // A zero-length bounded burst completes without leaving idle.
               if (!cfg_continuous && (cfg_len == '0)) begin
                  done_d = 1'b1;
               end else if (cfg_skip != '0) begin
                  state_d = StSkip;
               end else begin
                  state_d = StCapture;
               end
            end
         end

         StSkip: begin
            if (cfg_stop) begin
               state_d   = StIdle;
               aborted_d = 1'b1;
            end else if (bus.s_valid) begin
               skip_d = skip_q - SKIP_WIDTH'(1);
               if (skip_q == SKIP_WIDTH'(1)) begin
                  state_d = StCapture;
               end
            end
         end

         StCapture: begin
            if (cfg_stop) begin
               state_d   = StIdle;
               aborted_d = 1'b1;
            end else if (bus.s_valid) begin
               if (bus.fifo_full) begin
                  drop_inc   = 1'b1;
                  overflow_d = 1'b1;
               end else begin
                  fifo_wr_d   = 1'b1;
                  fifo_data_d = bus.s_data;
                  sample_d    = sample_inc;
                  // done is registered alongside the final write strobe.
                  if (!cont_q && (sample_inc == len_q)) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         sample_q    <= '0;
         skip_q      <= '0;
         cont_q      <= 1'b0;
         fifo_wr_q   <= 1'b0;
         fifo_data_q <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sample_q    <= sample_d;
         skip_q      <= skip_d;
         cont_q      <= cont_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_data_q <= fifo_data_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         overflow_q  <= overflow_d;
      end
   end

   sat_counter #(
      .WIDTH (DROP_WIDTH)
   ) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (drop_clr),
      .inc   (drop_inc),
      .count (drop_cnt)
   );

   assign bus.fifo_wr   = fifo_wr_q;
   assign bus.fifo_data = fifo_data_q;
   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign overflow      = overflow_q;
   assign sample_cnt    = sample_q;

endmodule

// File: tb/tb_afe_rx_burst_ctrl.sv
// Scoreboard bench for afe_rx_burst_ctrl; a second instance with a 2-bit drop
// counter shares the stimulus to exercise saturation.
module tb_afe_rx_burst_ctrl;

   logic        clk;
   logic        reset;
   logic        cfg_start;
   logic        cfg_stop;
   logic        cfg_continuous;
   logic [15:0] cfg_len;
   logic [7:0]  cfg_skip;
   logic        busy, done, aborted, overflow;
   logic [15:0] drop_cnt, sample_cnt;
   logic        busy2, done2, aborted2, overflow2;
   logic [1:0]  drop_cnt2;
   logic [15:0] sample_cnt2;

   afe_rx_burst_ctrl_if #(.IQ_PAIR_WIDTH(24)) bus ();
   afe_rx_burst_ctrl_if #(.IQ_PAIR_WIDTH(24)) bus2 ();

   assign bus2.s_valid   = bus.s_valid;
   assign bus2.s_data    = bus.s_data;
   assign bus2.fifo_full = bus.fifo_full;

   afe_rx_burst_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .cfg_continuous (cfg_continuous),
      .cfg_len        (cfg_len),
      .cfg_skip       (cfg_skip),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted),
      .overflow       (overflow),
      .drop_cnt       (drop_cnt),
      .sample_cnt     (sample_cnt)
   );

   afe_rx_burst_ctrl #(.DROP_WIDTH(2)) dut2 (
      .clk            (clk),
      .reset          (reset),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .cfg_continuous (cfg_continuous),
      .cfg_len        (cfg_len),
      .cfg_skip       (cfg_skip),
      .bus            (bus2),
      .busy           (busy2),
      .done           (done2),
      .aborted        (aborted2),
      .overflow       (overflow2),
      .drop_cnt       (drop_cnt2),
      .sample_cnt     (sample_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   int          wr_cnt, done_cnt, abort_cnt, wr_at_done;
   logic        done_with_wr;
   logic [23:0] e, o;

   // One clock: inputs were set before the edge; outputs sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (bus.fifo_wr === 1'b1) begin
         obs_q.push_back(bus.fifo_data);
         wr_cnt++;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_with_wr = bus.fifo_wr;
         wr_at_done   = wr_cnt;
      end
      if (aborted === 1'b1) abort_cnt++;
   endtask

   task automatic clr_obs();
      exp_q.delete();
      obs_q.delete();
      wr_cnt       = 0;
      done_cnt     = 0;
      abort_cnt    = 0;
      wr_at_done   = -1;
      done_with_wr = 1'b0;
   endtask

   // Accepted start pulse, then scramble config to prove it was latched.
   task automatic start(input logic cont, input logic [15:0] len, input logic [7:0] skip);
      cfg_continuous = cont;
      cfg_len        = len;
      cfg_skip       = skip;
      cfg_start      = 1'b1;
      tick();
      cfg_start      = 1'b0;
      cfg_len        = 16'($urandom);
      cfg_skip       = 8'($urandom);
      cfg_continuous = ~cont;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cfg_start = 0; cfg_stop = 0; cfg_continuous = 0; cfg_len = 0; cfg_skip = 0;
      bus.s_valid = 0; bus.s_data = 0; bus.fifo_full = 0;
      repeat (3) @(negedge clk);
      checks++; if (bus.fifo_wr !== 1'b0) begin errors++; $display("FAIL rst_fifo_wr got=%b want=0", bus.fifo_wr); end
      checks++; if (bus.fifo_data !== 24'd0) begin errors++; $display("FAIL rst_fifo_data got=%h want=0", bus.fifo_data); end
      checks++; if ({busy, done, aborted, overflow} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b want=0000", {busy, done, aborted, overflow}); end
      checks++; if (drop_cnt !== 16'd0 || sample_cnt !== 16'd0) begin errors++; $display("FAIL rst_counts got drop=%0d samp=%0d want 0 0", drop_cnt, sample_cnt); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_burst();
      clr_obs();
      start(1'b0, 16'd8, 8'd0);
      for (int i = 0; i < 12; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'hA00000 + 24'(i);
         if (i < 8) exp_q.push_back(bus.s_data);
         tick();
      end
      bus.s_valid = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL burst_data got=%h want=%h", o, e); end
      end
      checks++; if (done_cnt != 1 || done_with_wr !== 1'b1 || wr_at_done != 8) begin errors++; $display("FAIL burst_done got cnt=%0d wr=%b at=%0d want 1 1 8", done_cnt, done_with_wr, wr_at_done); end
      checks++; if (sample_cnt !== 16'd8) begin errors++; $display("FAIL burst_sample_cnt got=%0d want=8", sample_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy got=%b want=0", busy); end
   endtask

   task automatic test_skip();
      clr_obs();
      start(1'b0, 16'd4, 8'd3);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL skip_busy got=%b want=1", busy); end
      for (int i = 0; i < 10; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'(i);
         if (i >= 3 && i < 7) exp_q.push_back(bus.s_data);
         tick();
      end
      bus.s_valid = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL skip_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL skip_data got=%h want=%h", o, e); end
      end
      checks++; if (done_cnt != 1 || sample_cnt !== 16'd4) begin errors++; $display("FAIL skip_done got done=%0d samp=%0d want 1 4", done_cnt, sample_cnt); end
   endtask

   task automatic test_overflow();
      int pushed;
      clr_obs();
      pushed = 0;
      start(1'b0, 16'd10, 8'd0);
      for (int i = 0; i < 16; i++) begin
         bus.s_valid   = 1'b1;
         bus.s_data    = 24'h5A0000 + 24'(i);
         bus.fifo_full = (i >= 3 && i <= 5);
         if (!bus.fifo_full && pushed < 10) begin exp_q.push_back(bus.s_data); pushed++; end
         tick();
      end
      bus.s_valid = 1'b0; bus.fifo_full = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL ovf_data got=%h want=%h", o, e); end
      end
      checks++; if (drop_cnt !== 16'd3 || drop_cnt2 !== 2'd3) begin errors++; $display("FAIL ovf_drop_cnt got=%0d/%0d want 3/3", drop_cnt, drop_cnt2); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
      checks++; if (done_cnt != 1 || wr_at_done != 10) begin errors++; $display("FAIL ovf_done got cnt=%0d at=%0d want 1 10", done_cnt, wr_at_done); end
      clr_obs();
      start(1'b0, 16'd2, 8'd0);
      checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_clear got ovf=%b drop=%0d want 0 0", overflow, drop_cnt); end
      bus.s_valid = 1'b1;
      repeat (3) tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic test_stop();
      clr_obs();
      start(1'b1, 16'd0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'h330000 + 24'(i);
         exp_q.push_back(bus.s_data);
         tick();
      end
      bus.s_data = 24'h33FFFF;
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      repeat (4) tick();
      bus.s_valid = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stop_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL stop_data got=%h want=%h", o, e); end
      end
      checks++; if (abort_cnt != 1 || done_cnt != 0) begin errors++; $display("FAIL stop_pulses got abort=%0d done=%0d want 1 0", abort_cnt, done_cnt); end
      checks++; if (busy !== 1'b0 || sample_cnt !== 16'd5) begin errors++; $display("FAIL stop_state got busy=%b samp=%0d want 0 5", busy, sample_cnt); end
   endtask

   task automatic test_edges();
      // Zero-length bounded burst.
      clr_obs();
      bus.s_valid = 1'b0;
      start(1'b0, 16'd0, 8'd0);
      bus.s_valid = 1'b1;
      repeat (3) tick();
      bus.s_valid = 1'b0;
      checks++; if (done_cnt != 1 || busy !== 1'b0 || wr_cnt != 0) begin errors++; $display("FAIL len0 got done=%0d busy=%b wr=%0d want 1 0 0", done_cnt, busy, wr_cnt); end
      // Start and stop together.
      clr_obs();
      cfg_continuous = 1'b0; cfg_len = 16'd5; cfg_skip = 8'd0;
      cfg_start = 1'b1; cfg_stop = 1'b1;
      tick();
      cfg_start = 1'b0; cfg_stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got=%b want=0", busy); end
      bus.s_valid = 1'b1;
      repeat (3) tick();
      bus.s_valid = 1'b0;
      checks++; if (wr_cnt != 0 || done_cnt != 0 || abort_cnt != 0) begin errors++; $display("FAIL start_stop_idle got wr=%0d done=%0d abort=%0d want 0 0 0", wr_cnt, done_cnt, abort_cnt); end
      // Start while busy.
      clr_obs();
      start(1'b0, 16'd4, 8'd0);
      for (int i = 0; i < 8; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'h770000 + 24'(i);
         if (i < 4) exp_q.push_back(bus.s_data);
         if (i == 2) begin cfg_len = 16'd1; cfg_skip = 8'd5; cfg_continuous = 1'b0; end
         cfg_start = (i == 2);
         tick();
      end
      cfg_start = 1'b0; bus.s_valid = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_start_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL busy_start_data got=%h want=%h", o, e); end
      end
      checks++; if (done_cnt != 1 || sample_cnt !== 16'd4) begin errors++; $display("FAIL busy_start_done got done=%0d samp=%0d want 1 4", done_cnt, sample_cnt); end
      // Five drops: 16-bit counter reads 5, 2-bit counter saturates at 3.
      clr_obs();
      start(1'b0, 16'd2, 8'd0);
      for (int i = 0; i < 9; i++) begin
         bus.s_valid   = 1'b1;
         bus.s_data    = 24'h990000 + 24'(i);
         bus.fifo_full = (i < 5);
         if (i == 5 || i == 6) exp_q.push_back(bus.s_data);
         tick();
      end
      bus.s_valid = 1'b0; bus.fifo_full = 1'b0;
      checks++; if (drop_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_drop_cnt got=%0d want=3", drop_cnt2); end
      checks++; if (drop_cnt !== 16'd5) begin errors++; $display("FAIL wide_drop_cnt got=%0d want=5", drop_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL sat_data got=%h want=%h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      clr_obs();
      start(1'b0, 16'd8, 8'd0);
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'h440000 + 24'(i);
         exp_q.push_back(bus.s_data);
         tick();
      end
      reset = 1'b1;
      #1;
      checks++; if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 24'd0) begin errors++; $display("FAIL rstmid_fifo got wr=%b data=%h want 0 0", bus.fifo_wr, bus.fifo_data); end
      checks++; if (busy !== 1'b0 || sample_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_state got busy=%b samp=%0d drop=%0d want 0 0 0", busy, sample_cnt, drop_cnt); end
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();
      checks++; if (done_cnt != 0 || abort_cnt != 0) begin errors++; $display("FAIL rstmid_pulses got done=%0d abort=%0d want 0 0", done_cnt, abort_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      // Fresh burst after reset.
      clr_obs();
      bus.s_valid = 1'b0;
      start(1'b0, 16'd3, 8'd0);
      for (int i = 0; i < 5; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 24'h880000 + 24'(i);
         if (i < 3) exp_q.push_back(bus.s_data);
         tick();
      end
      bus.s_valid = 1'b0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fresh_writes got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL fresh_data got=%h want=%h", o, e); end
      end
      checks++; if (done_cnt != 1 || sample_cnt !== 16'd3) begin errors++; $display("FAIL fresh_done got done=%0d samp=%0d want 1 3", done_cnt, sample_cnt); end
   endtask

   initial begin
      clr_obs();
      test_reset();
      test_burst();
      test_skip();
      test_overflow();
      test_stop();
      test_edges();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
